// File: rtl/key_expansion_ctrl.sv
// Expands one cipher key into NR_ROUNDS round keys by stepping an external
// key_schedule once per round and writing each round key to the round-key RAM.
module key_expansion_ctrl #(
  parameter int KEY_SIZE   = 128,
  parameter int BLOCK_SIZE = 64,
  parameter int NR_ROUNDS  = 32,
  parameter int ADDR_W     = 5,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [KEY_SIZE-1:0]   key_in,
  input  logic                  key_valid,
  output logic                  key_ready,
  output logic [KEY_SIZE-1:0]   ks_key,
  output logic [BLOCK_SIZE-1:0] ks_round_ctr,
  output logic                  ks_start,
  input  logic [KEY_SIZE-1:0]   ks_out_key,
  input  logic                  ks_finished,
  output logic                  rk_wr_en,
  output logic [ADDR_W-1:0]     rk_wr_addr,
  output logic [BLOCK_SIZE-1:0] rk_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            dbg_state
);

  // Handshake: a key transfers on any rising clk edge where key_valid and
  // key_ready are both 1. key_ready is high only in IDLE, DONE and ERROR, so a
  // key offered during an expansion is simply not taken (it is never queued).

  typedef enum logic [2:0] {
    S_IDLE, S_EMIT0, S_START, S_WAIT_FIN, S_WRITE, S_WAIT_CLR, S_DONE, S_ERROR
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]     T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NR_ROUNDS - 1);
  localparam logic [ADDR_W-1:0] RUN_LAST = ADDR_W'((NR_ROUNDS > 1) ? NR_ROUNDS - 2 : 0);

  state_t                state;
  logic [KEY_SIZE-1:0]   cur_key;
  logic [ADDR_W-1:0]     idx;
  logic [TW-1:0]         timer;
  logic                  fin_q;
  logic                  accept;
  logic                  fin_rise;
  logic [ADDR_W-1:0]     idx_inc;
  logic [TW-1:0]         timer_inc;

  assign accept    = key_valid & key_ready;
  assign fin_rise  = ks_finished & ~fin_q;
  assign idx_inc   = (idx == IDX_LAST) ? idx : idx + ADDR_W'(1);
  assign timer_inc = (timer == T_LAST) ? timer : timer + TW'(1);
  assign dbg_state = state;

  // All outputs are registered: each transition loads the values that the
  // destination state presents for its whole cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cur_key      <= '0;
      idx          <= '0;
      timer        <= '0;
      fin_q        <= 1'b0;
      key_ready    <= 1'b1;
      ks_key       <= '0;
      ks_round_ctr <= '0;
      ks_start     <= 1'b0;
      rk_wr_en     <= 1'b0;
      rk_wr_addr   <= '0;
      rk_wr_data   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      fin_q    <= ks_finished;
      rk_wr_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (accept) begin
            state      <= S_EMIT0;
            cur_key    <= key_in;
            idx        <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            key_ready  <= 1'b0;
            rk_wr_en   <= 1'b1;
            rk_wr_addr <= '0;
            rk_wr_data <= key_in[BLOCK_SIZE-1:0];
          end else if (state == S_DONE) begin
            state <= S_IDLE;
          end
        end
        S_EMIT0: begin
          if (NR_ROUNDS == 1) begin
            state     <= S_DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            key_ready <= 1'b1;
          end else begin
            state <= S_START;
          end
        end
        S_START: begin
          ks_key       <= cur_key;
          ks_round_ctr <= BLOCK_SIZE'(idx);
          ks_start     <= 1'b1;
          timer        <= '0;
          state        <= S_WAIT_FIN;
        end
        S_WAIT_FIN: begin
          // Only a fresh 0->1 of finished counts; a level left over from the
          // previous run (or held high across START) is ignored.
          if (fin_rise) begin
            cur_key    <= ks_out_key;
            ks_start   <= 1'b0;
            rk_wr_en   <= 1'b1;
            rk_wr_addr <= idx + ADDR_W'(1);
            rk_wr_data <= ks_out_key[BLOCK_SIZE-1:0];
            state      <= S_WRITE;
          end else if (timer == T_LAST) begin
            ks_start  <= 1'b0;
            err       <= 1'b1;
            busy      <= 1'b0;
            key_ready <= 1'b1;
            state     <= S_ERROR;
          end else begin
            timer <= timer_inc;
          end
        end
        S_WRITE: begin
          idx <= idx_inc;
          if (idx == RUN_LAST) begin
            state     <= S_DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            key_ready <= 1'b1;
          end else begin
            timer <= '0;
            state <= S_WAIT_CLR;
          end
        end
        S_WAIT_CLR: begin
          if (!ks_finished) begin
            state <= S_START;
          end else if (timer == T_LAST) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            key_ready <= 1'b1;
            state     <= S_ERROR;
          end else begin
            timer <= timer_inc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
